// File: rtl/branch_predict_unit_if.sv
// Resolution/prediction bus for branch_predict_unit.
// The slave side is the predictor. The master side drives fetch and resolve requests.
interface branch_predict_unit_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
);
  logic [XLEN-1:0]  pred_pc;
  logic             pred_taken;
  logic             res_valid;
  logic [XLEN-1:0]  res_pc;
  logic [XLEN-1:0]  ru_X1;
  logic [XLEN-1:0]  ru_X2;
  logic [4:0]       BrOp;
  logic             res_pred;
  logic             clr_stats;
  logic             out_valid;
  logic             branch_taken;
  logic             mispredict;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mis_count;

  modport master (
    output pred_pc, res_valid, res_pc, ru_X1, ru_X2, BrOp, res_pred, clr_stats,
    input  pred_taken, out_valid, branch_taken, mispredict, br_count, mis_count
  );

  modport slave (
    input  pred_pc, res_valid, res_pc, ru_X1, ru_X2, BrOp, res_pred, clr_stats,
    output pred_taken, out_valid, branch_taken, mispredict, br_count, mis_count
  );
endinterface

// File: rtl/branch_predict_unit.sv
// RISC-V branch resolver with a PC-indexed BHT of 2-bit saturating counters,
// registered resolution/mispredict flags and saturating statistics counters.
module branch_predict_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_predict_unit_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  localparam logic [4:0] BR_EQ  = 5'd1;
  localparam logic [4:0] BR_NE  = 5'd2;
  localparam logic [4:0] BR_LT  = 5'd3;
  localparam logic [4:0] BR_GE  = 5'd4;
  localparam logic [4:0] BR_LTU = 5'd5;
  localparam logic [4:0] BR_GEU = 5'd6;

  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] res_idx;
  logic             cond;
  logic             op_ok;
  logic             accept;

  assign pred_idx       = bus.pred_pc[IDX_W+1:2];
  assign res_idx        = bus.res_pc[IDX_W+1:2];
  // Reads the pre-edge counter, so a same-cycle update shows up one cycle later.
  assign bus.pred_taken = bht[pred_idx][1];

  always_comb begin
    cond  = 1'b0;
    op_ok = 1'b1;
    case (bus.BrOp)
      BR_EQ:   cond = (bus.ru_X1 == bus.ru_X2);
      BR_NE:   cond = (bus.ru_X1 != bus.ru_X2);
      BR_LT:   cond = ($signed(bus.ru_X1) <  $signed(bus.ru_X2));
      BR_GE:   cond = ($signed(bus.ru_X1) >= $signed(bus.ru_X2));
      BR_LTU:  cond = (bus.ru_X1 <  bus.ru_X2);
      BR_GEU:  cond = (bus.ru_X1 >= bus.ru_X2);
      default: op_ok = 1'b0;
    endcase
  end

  assign accept = bus.res_valid & op_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid    <= 1'b0;
      bus.branch_taken <= 1'b0;
      bus.mispredict   <= 1'b0;
      bus.br_count     <= '0;
      bus.mis_count    <= '0;
    end else begin
      bus.out_valid    <= accept;
      bus.branch_taken <= accept & cond;
      bus.mispredict   <= accept & (cond != bus.res_pred);
      // Clear beats a coincident branch: that branch is simply not counted.
      if (bus.clr_stats) begin
        bus.br_count  <= '0;
        bus.mis_count <= '0;
      end else if (accept) begin
        if (bus.br_count != '1)
          bus.br_count <= bus.br_count + 1'b1;
        if ((cond != bus.res_pred) && (bus.mis_count != '1))
          bus.mis_count <= bus.mis_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++)
        bht[i] <= 2'b01;
    end else if (accept) begin
      if (cond) begin
        if (bht[res_idx] != 2'b11)
          bht[res_idx] <= bht[res_idx] + 2'b01;
      end else begin
        if (bht[res_idx] != 2'b00)
          bht[res_idx] <= bht[res_idx] - 2'b01;
      end
    end
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.pred_pc[XLEN-1:IDX_W+2], bus.pred_pc[1:0],
                            bus.res_pc[XLEN-1:IDX_W+2], bus.res_pc[1:0]};
endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: directed vectors push expected
// registered results; a monitor pops and compares one entry per clock.
module tb_branch_predict_unit;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_predict_unit_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  branch_predict_unit #(
    .XLEN(XLEN), .BHT_ENTRIES(64), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic v;
    logic t;
    logic m;
    int   br;
    int   mc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] x1,
                       input logic [31:0] x2, input logic [4:0] op, input logic pr,
                       input logic clr, input logic ev, input logic et,
                       input logic em, input int eb, input int emc);
    exp_t e;
    bus.res_valid = v;
    bus.res_pc    = pc;
    bus.ru_X1     = x1;
    bus.ru_X2     = x2;
    bus.BrOp      = op;
    bus.res_pred  = pr;
    bus.clr_stats = clr;
    e.v = ev; e.t = et; e.m = em; e.br = eb; e.mc = emc;
    q.push_back(e);
  endtask

  task automatic pred_chk(input string name, input logic [31:0] pc, input logic exp);
    bus.pred_pc = pc;
    #1;
    chk(name, int'(bus.pred_taken), int'(exp));
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("out_valid",    int'(bus.out_valid),    int'(e.v));
      chk("branch_taken", int'(bus.branch_taken), int'(e.t));
      chk("mispredict",   int'(bus.mispredict),   int'(e.m));
      chk("br_count",     int'(bus.br_count),     e.br);
      chk("mis_count",    int'(bus.mis_count),    e.mc);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int eb;
    int em;
    bus.pred_pc = 32'h100; bus.res_valid = 1'b0; bus.res_pc = '0;
    bus.ru_X1 = '0; bus.ru_X2 = '0; bus.BrOp = '0; bus.res_pred = 1'b0;
    bus.clr_stats = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst out_valid", int'(bus.out_valid), 0);
    chk("rst br_count",  int'(bus.br_count), 0);
    chk("rst mis_count", int'(bus.mis_count), 0);
    pred_chk("rst pred 0x100", 32'h100, 1'b0);
    pred_chk("rst pred 0x3c",  32'h3c,  1'b0);

    // Train idx0 up to saturation, then one not-taken keeps it predicting taken.
    @(negedge clk);
    drive(1, 32'h100, 10, 10, 5'd1, 0, 0, 1, 1, 1, 1, 1); @(negedge clk);
    pred_chk("pred 0x100 after 1 taken", 32'h100, 1'b1);
    drive(1, 32'h100, 10, 10, 5'd1, 1, 0, 1, 1, 0, 2, 1); @(negedge clk);
    drive(1, 32'h100, 10, 10, 5'd1, 1, 0, 1, 1, 0, 3, 1); @(negedge clk);
    drive(1, 32'h100, 10, 10, 5'd1, 1, 0, 1, 1, 0, 4, 1); @(negedge clk);
    drive(1, 32'h100, 10, 10, 5'd2, 1, 0, 1, 0, 1, 5, 2); @(negedge clk);
    pred_chk("pred 0x100 hysteresis", 32'h100, 1'b1);

    bus.pred_pc = 32'h104;
    drive(1, 32'h104, 5, 5, 5'd1, 0, 0, 1, 1, 1, 6, 3);
    #1;
    chk("same-index pre-update", int'(bus.pred_taken), 0);
    @(negedge clk);
    chk("same-index post-update", int'(bus.pred_taken), 1);

    drive(1, 32'h108, 32'hFFFF_FFFF, 1, 5'd3, 1, 0, 1, 1, 0, 7, 3); @(negedge clk);
    drive(1, 32'h10C, 32'hFFFF_FFFF, 1, 5'd4, 1, 0, 1, 0, 1, 8, 4); @(negedge clk);
    drive(1, 32'h110, 1, 32'hFFFF_FFFF, 5'd5, 1, 0, 1, 1, 0, 9, 4); @(negedge clk);
    drive(1, 32'h114, 32'hFFFF_FFFF, 1, 5'd6, 1, 0, 1, 1, 0, 10, 4); @(negedge clk);
    pred_chk("pred LT idx2", 32'h108, 1'b1);

    drive(1, 32'h10C, 10, 10, 5'd0, 1, 0, 0, 0, 0, 10, 4); @(negedge clk);
    drive(1, 32'h10C, 10, 10, 5'd7, 0, 0, 0, 0, 0, 10, 4); @(negedge clk);
    drive(1, 32'h10C, 10, 10, 5'd31, 0, 0, 0, 0, 0, 10, 4); @(negedge clk);
    drive(0, 32'h10C, 10, 10, 5'd1, 0, 0, 0, 0, 0, 10, 4); @(negedge clk);
    pred_chk("no update on idle/reserved", 32'h10C, 1'b0);
    pred_chk("alias 0x200", 32'h200, 1'b1);
    pred_chk("alias 0x204", 32'h204, 1'b1);
    pred_chk("pc low bits ignored", 32'h207, 1'b1);

    drive(1, 32'h100, 10, 10, 5'd1, 0, 1, 1, 1, 1, 0, 0); @(negedge clk);
    drive(1, 32'h100, 1, 2, 5'd2, 0, 0, 1, 1, 1, 1, 1); @(negedge clk);

    // idx3 sits at 0: another not-taken must not wrap, so one taken leaves it at 1.
    drive(1, 32'h10C, 0, 1, 5'd4, 0, 0, 1, 0, 0, 2, 1); @(negedge clk);
    drive(1, 32'h10C, 3, 3, 5'd1, 0, 0, 1, 1, 1, 3, 2); @(negedge clk);
    pred_chk("floor saturation idx3", 32'h10C, 1'b0);

    eb = 3; em = 2;
    for (int i = 0; i < 14; i++) begin
      eb = (eb < 15) ? eb + 1 : 15;
      em = (em < 15) ? em + 1 : 15;
      drive(1, 32'h118, 7, 7, 5'd1, 0, 0, 1, 1, 1, eb, em); @(negedge clk);
    end
    drive(1, 32'h118, 7, 7, 5'd2, 1, 0, 1, 0, 1, 15, 15); @(negedge clk);

    bus.pred_pc = 32'h100;
    drive(1, 32'h100, 10, 10, 5'd1, 1, 0, 1, 1, 0, 15, 15);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst out_valid",    int'(bus.out_valid), 0);
    chk("midrst branch_taken", int'(bus.branch_taken), 0);
    chk("midrst br_count",     int'(bus.br_count), 0);
    chk("midrst mis_count",    int'(bus.mis_count), 0);
    chk("midrst pred 0x100",   int'(bus.pred_taken), 0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 32'h100, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 0); @(negedge clk);
    pred_chk("post-rst pred 0x118", 32'h118, 1'b0);

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the combinational branch comparator.
- Resolves RISC-V conditional branches (same BrOp encoding) and keeps a PC-indexed branch history table (BHT) of 2-bit saturating counters.
- Provides a combinational taken-prediction for a fetch PC, registered resolution/mispredict flags, and saturating statistics counters.
- Sits between register-file read and PC-select logic; prepares the core for a pipelined fetch.

Parameters:
- XLEN, 32, operand and PC width.
- BHT_ENTRIES, 64, number of 2-bit counters; must be a power of two, at least 2. IDX_W = $clog2(BHT_ENTRIES).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- pred_pc  in  XLEN  fetch PC to predict.
- pred_taken  out  1  combinational; MSB of BHT[pred_pc[IDX_W+1:2]].
- res_valid  in  1  a branch is being resolved this cycle.
- res_pc  in  XLEN  PC of the branch being resolved.
- ru_X1  in  XLEN  rs1 operand.
- ru_X2  in  XLEN  rs2 operand.
- BrOp  in  5  NOP=0, EQ=1, NE=2, LT=3, GE=4, LTU=5, GEU=6; 7..31 reserved.
- res_pred  in  1  prediction that was used for this branch.
- clr_stats  in  1  synchronous clear of br_count and mis_count.
- out_valid  out  1  registered; resolution result valid.
- branch_taken  out  1  registered condition result.
- mispredict  out  1  registered; branch_taken != res_pred.
- br_count  out  CNT_W  resolved-branch count, saturating.
- mis_count  out  CNT_W  mispredict count, saturating.

Behaviour:
- Reset (async, immediate):
  - out_valid, branch_taken, mispredict, br_count and mis_count all go to 0.
  - Every BHT entry goes to 2'b01 (weakly not-taken), so pred_taken=0 for every PC.
- Condition evaluation:
  - EQ/NE use bitwise equality.
  - LT/GE compare signed XLEN.
  - LTU/GEU compare unsigned.
- A branch is accepted when res_valid=1 and BrOp is in 1..6.
- On an accepted branch, at the next rising edge:
  - out_valid is set to 1.
  - branch_taken is set to the condition result.
  - mispredict is set to (condition != res_pred).
  - The BHT entry at idx = res_pc[IDX_W+1:2] is updated: taken means +1 saturating at 3; not-taken means -1 saturating at 0.
  - br_count increments by 1, and mis_count increments by 1 if mispredicted. Both saturate at all-ones and never wrap.
- Latency: 1 cycle from res_valid to out_valid; one result per cycle; no backpressure.
- Not accepted (res_valid=0, BrOp=NOP, or BrOp reserved):
  - Next cycle out_valid=0, branch_taken=0, mispredict=0.
  - No BHT update and no count changes.
- Same-index read/write in one cycle: pred_taken shows the pre-update value; the new value is visible the cycle after the edge.
- clr_stats=1 together with an accepted branch:
  - The clear wins; both counts become 0 and the current branch is not counted.
  - The BHT update and the registered outputs still occur.
- Aliasing: PCs differing only above bit IDX_W+1 share an entry; this is intended.
- PC bits [1:0] are ignored.
- rst asserted mid-operation discards any in-flight result and restores all reset values at once.

Test Plan:
- Reset: rst=1 then 0, any pred_pc -> pred_taken=0, out_valid=0, br_count=0, mis_count=0.
- BEQ, ru_X1=10, ru_X2=10, res_pc=0x100, res_pred=0:
  - Next cycle: out_valid=1, branch_taken=1, mispredict=1, br_count=1, mis_count=1.
  - pred_pc=0x100 then gives pred_taken=1 (counter=2).
- Saturation and hysteresis: 3 more taken BEQs at 0x100 (counter=3), then BNE with 10/10 (not taken) -> counter=2, pred_taken stays 1.
- Signed/unsigned, each with res_pred=1:
  - BLT FFFFFFFF,1 -> taken=1.
  - BGE FFFFFFFF,1 -> taken=0, mispredict=1.
  - BLTU 1,FFFFFFFF -> taken=1.
  - BGEU FFFFFFFF,1 -> taken=1.
- NOP and aliasing:
  - BrOp=0 with res_valid=1 -> out_valid=0, counts unchanged.
  - With BHT_ENTRIES=64, training 0x100 taken makes pred_pc=0x200 predict 1.
- clr_stats with a simultaneous taken branch -> both counts become 0 and branch_taken=1 next cycle. Then assert rst between edges -> all outputs 0 immediately and pred_taken=0 at 0x100.
